// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs,
// ALU operations, datapath mux selects and the FSM state type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MADDR, S_MRD, S_MWB, S_MWR, S_REX,
        S_RWB, S_IEX, S_IWB, S_BR, S_JMP, S_JAL, S_JR, S_TRAP
    } state_t;

    // {valid, alu op}; an unknown func comes back with valid=0
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_hs_mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the wait cycle that
// would reach MEM_WAIT_MAX.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wait_en,
    output logic expired
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    assign expired = wait_en && (cnt == CW'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (wait_en && !expired)
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/mips_mc_ctrl_hs.sv
// Multi-cycle MIPS controller with memory ready handshake, wait timeout,
// sticky illegal/mem_err traps and a retired-instruction counter.
import mips_ctrl_pkg::*;

module mips_mc_ctrl_hs #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opc,
    input  logic [5:0]        func,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              PCLoad,
    output logic              IorD,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              JalSig1,
    output logic              JalSig2,
    output logic              MemToReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [2:0]        ALUOperation,
    output logic [1:0]        PCSrc,
    output logic              illegal,
    output logic              mem_err,
    output logic [PERF_W-1:0] instret
);
    state_t     state_q, state_d;
    logic       waiting, expired, trap_ill, trap_mem;
    logic [3:0] rdec;

    assign rdec    = rtype_alu(func);
    assign waiting = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);

    // any state change restarts the count, so each access gets a fresh budget
    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_d != state_q),
        .wait_en (waiting && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RST;
            illegal <= 1'b0;
            mem_err <= 1'b0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (trap_ill) illegal <= 1'b1;
            if (trap_mem) mem_err <= 1'b1;
            if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST)
                instret <= instret + PERF_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        trap_ill     = 1'b0;
        trap_mem     = 1'b0;
        PCLoad       = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        JalSig1      = 1'b0;
        JalSig2      = 1'b0;
        MemToReg     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        ALUOperation = ALU_AND;
        PCSrc        = PC_ALU;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                MemRead      = 1'b1;
                ALUSrcB      = SRCB_4;
                ALUOperation = ALU_ADD;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCLoad  = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    trap_mem = 1'b1;
                    state_d  = S_TRAP;
                end
            end
            S_DECODE: begin
                ALUSrcB      = SRCB_IMM2;
                ALUOperation = ALU_ADD;
                case (opc)
                    OP_RTYPE:        state_d = (func == FN_JR) ? S_JR : S_REX;
                    OP_LW, OP_SW:    state_d = S_MADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BR;
                    OP_ADDI, OP_SLTI: state_d = S_IEX;
                    OP_J:            state_d = S_JMP;
                    OP_JAL:          state_d = S_JAL;
                    default: begin
                        trap_ill = 1'b1;
                        state_d  = S_TRAP;
                    end
                endcase
            end
            S_REX: begin
                ALUSrcA      = 1'b1;
                ALUOperation = rdec[2:0];
                trap_ill     = !rdec[3];
                state_d      = rdec[3] ? S_RWB : S_TRAP;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_IEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                ALUOperation = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d      = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                ALUOperation = ALU_ADD;
                state_d      = (opc == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MWB;
                else if (expired) begin
                    trap_mem = 1'b1;
                    state_d  = S_TRAP;
                end
            end
            S_MWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                else if (expired) begin
                    trap_mem = 1'b1;
                    state_d  = S_TRAP;
                end
            end
            S_BR: begin
                ALUSrcA      = 1'b1;
                ALUOperation = ALU_SUB;
                PCSrc        = PC_ALUOUT;
                PCLoad       = (opc == OP_BNE) ? !zero : zero;
                state_d      = S_FETCH;
            end
            S_JMP: begin
                PCSrc   = PC_JUMP;
                PCLoad  = 1'b1;
                state_d = S_FETCH;
            end
            // PC already holds PC+4 here, so the link value is written directly
            S_JAL: begin
                JalSig1  = 1'b1;
                JalSig2  = 1'b1;
                RegWrite = 1'b1;
                PCSrc    = PC_JUMP;
                PCLoad   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCSrc   = PC_REG;
                PCLoad  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_mips_mc_ctrl_hs.sv
// Cycle-accurate scoreboard bench: dut_a (wait max 15, 4-bit instret) runs the
// instruction mix; dut_b (wait max 3) exercises the memory timeout.
module tb_mips_mc_ctrl_hs;
    typedef struct packed {
        logic PCLoad, IorD, IRWrite, RegDst, JalSig1, JalSig2, MemToReg;
        logic MemRead, MemWrite, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUOperation;
        logic [1:0] PCSrc;
        logic illegal, mem_err;
    } ctl_t;

    typedef enum {K_FETCH, K_DEC, K_REX, K_RWB, K_IEX, K_IWB, K_MADDR, K_MRD, K_MWB,
                  K_MWR, K_BR, K_JMP, K_JAL, K_JR, K_TI, K_TM, K_ZERO} k_t;

    typedef struct { logic rdy; logic chk; ctl_t exp; } ent_t;

    logic clk = 1'b0, rst = 1'b0, rst_b = 1'b0, zero = 1'b0;
    logic mem_ready = 1'b0, mem_ready_b = 1'b0;
    logic [5:0] opc = '0, func = '0;
    ctl_t oa, ob;
    logic [3:0]  instret_a;
    logic [31:0] instret_b;
    ent_t sbq[$];
    int checks = 0, passes = 0, exp_ret = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl_hs #(.MEM_WAIT_MAX(15), .PERF_W(4)) dut_a (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
        .PCLoad(oa.PCLoad), .IorD(oa.IorD), .IRWrite(oa.IRWrite), .RegDst(oa.RegDst),
        .JalSig1(oa.JalSig1), .JalSig2(oa.JalSig2), .MemToReg(oa.MemToReg),
        .MemRead(oa.MemRead), .MemWrite(oa.MemWrite), .RegWrite(oa.RegWrite),
        .ALUSrcA(oa.ALUSrcA), .ALUSrcB(oa.ALUSrcB), .ALUOperation(oa.ALUOperation),
        .PCSrc(oa.PCSrc), .illegal(oa.illegal), .mem_err(oa.mem_err), .instret(instret_a));

    mips_mc_ctrl_hs #(.MEM_WAIT_MAX(3), .PERF_W(32)) dut_b (
        .clk(clk), .rst(rst_b), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready_b),
        .PCLoad(ob.PCLoad), .IorD(ob.IorD), .IRWrite(ob.IRWrite), .RegDst(ob.RegDst),
        .JalSig1(ob.JalSig1), .JalSig2(ob.JalSig2), .MemToReg(ob.MemToReg),
        .MemRead(ob.MemRead), .MemWrite(ob.MemWrite), .RegWrite(ob.RegWrite),
        .ALUSrcA(ob.ALUSrcA), .ALUSrcB(ob.ALUSrcB), .ALUOperation(ob.ALUOperation),
        .PCSrc(ob.PCSrc), .illegal(ob.illegal), .mem_err(ob.mem_err), .instret(instret_b));

    // expected control word for one cycle; mem_ready is randomised where ignored
    task automatic push(input k_t k, input logic rdy = 1'b1, input logic [2:0] op = 3'b010,
                        input logic pcl = 1'b0, input logic chk = 1'b1);
        ent_t e;
        ctl_t c;
        c = '0;
        case (k)
            K_FETCH: begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.ALUOperation = 3'b010;
                           c.PCLoad = rdy; c.IRWrite = rdy; end
            K_DEC:   begin c.ALUSrcB = 2'b11; c.ALUOperation = 3'b010; end
            K_REX:   begin c.ALUSrcA = 1; c.ALUOperation = op; end
            K_RWB:   begin c.RegDst = 1; c.RegWrite = 1; end
            K_IEX:   begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOperation = op; end
            K_IWB:   c.RegWrite = 1;
            K_MADDR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOperation = 3'b010; end
            K_MRD:   begin c.MemRead = 1; c.IorD = 1; end
            K_MWB:   begin c.MemToReg = 1; c.RegWrite = 1; end
            K_MWR:   begin c.MemWrite = 1; c.IorD = 1; end
            K_BR:    begin c.ALUSrcA = 1; c.ALUOperation = 3'b110; c.PCSrc = 2'b01; c.PCLoad = pcl; end
            K_JMP:   begin c.PCSrc = 2'b10; c.PCLoad = 1; end
            K_JAL:   begin c.JalSig1 = 1; c.JalSig2 = 1; c.RegWrite = 1; c.PCSrc = 2'b10; c.PCLoad = 1; end
            K_JR:    begin c.PCSrc = 2'b11; c.PCLoad = 1; end
            K_TI:    c.illegal = 1;
            K_TM:    c.mem_err = 1;
            default: c = '0;
        endcase
        e.rdy = (k inside {K_FETCH, K_MRD, K_MWR}) ? rdy : 1'($urandom);
        e.chk = chk;
        e.exp = c;
        sbq.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_ret = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (oa !== '0 || instret_a !== 4'd0)
            $display("FAIL reset_hold ctl=%h instret=%0d want 0/0", oa, instret_a);
        else passes++;
        rst = 1'b1;
        push(K_ZERO);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL rst_cycle ctl=%h want %h", oa, e.exp);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_fetch_wait();
        opc = 6'b000000; func = 6'b100000;
        push(K_FETCH, 1'b0); push(K_FETCH, 1'b0); push(K_FETCH, 1'b1);
        push(K_DEC); push(K_REX, 1'b1, 3'b010); push(K_RWB);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL fetch_wait ctl=%h want %h", oa, e.exp);
            else passes++;
            @(negedge clk);
        end
        exp_ret++;
        checks++;
        if (instret_a !== 4'(exp_ret)) $display("FAIL fetch_wait_instret got %0d want %0d", instret_a, 4'(exp_ret));
        else passes++;
    endtask

    task automatic test_branches();
        logic [5:0] bop [4] = '{6'b000101, 6'b000101, 6'b000100, 6'b000100};
        logic       bz  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       bpl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            opc = bop[i]; zero = bz[i];
            push(K_FETCH); push(K_DEC); push(K_BR, 1'b1, 3'b110, bpl[i]);
            while (sbq.size() > 0) begin
                ent_t e;
                e = sbq.pop_front();
                mem_ready = e.rdy; #1;
                checks++;
                if (oa !== e.exp) $display("FAIL branch%0d ctl=%h want %h", i, oa, e.exp);
                else passes++;
                @(negedge clk);
            end
            exp_ret++;
            checks++;
            if (instret_a !== 4'(exp_ret)) $display("FAIL branch_instret got %0d want %0d", instret_a, 4'(exp_ret));
            else passes++;
        end
        zero = 1'b0;
    endtask

    task automatic test_mem();
        opc = 6'b100011;
        push(K_FETCH); push(K_DEC); push(K_MADDR); push(K_MRD); push(K_MWB);
        push(K_FETCH); push(K_DEC); push(K_MADDR);
        push(K_MWR, 1'b0); push(K_MWR, 1'b0); push(K_MWR, 1'b0); push(K_MWR, 1'b1);
        for (int n = 0; sbq.size() > 0; n++) begin
            ent_t e;
            if (n == 5) opc = 6'b101011;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL mem_cyc%0d ctl=%h want %h", n, oa, e.exp);
            else passes++;
            @(negedge clk);
        end
        exp_ret += 2;
        checks++;
        if (instret_a !== 4'(exp_ret)) $display("FAIL mem_instret got %0d want %0d", instret_a, 4'(exp_ret));
        else passes++;
    endtask

    task automatic test_jumps();
        logic [5:0] jo [9] = '{6'b000011, 6'b000000, 6'b000010, 6'b001000, 6'b001010,
                               6'b000000, 6'b000000, 6'b000000, 6'b000000};
        logic [5:0] jf [9] = '{6'b000000, 6'b001000, 6'b000000, 6'b000000, 6'b000000,
                               6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] jop [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b111,
                                3'b110, 3'b000, 3'b001, 3'b111};
        k_t jk [3] = '{K_JAL, K_JR, K_JMP};
        for (int i = 0; i < 9; i++) begin
            opc = jo[i]; func = jf[i];
            push(K_FETCH); push(K_DEC);
            if (i < 3) push(jk[i]);
            else if (i < 5) begin push(K_IEX, 1'b1, jop[i]); push(K_IWB); end
            else begin push(K_REX, 1'b1, jop[i]); push(K_RWB); end
            while (sbq.size() > 0) begin
                ent_t e;
                e = sbq.pop_front();
                mem_ready = e.rdy; #1;
                checks++;
                if (oa !== e.exp) $display("FAIL instr%0d ctl=%h want %h", i, oa, e.exp);
                else passes++;
                @(negedge clk);
            end
            exp_ret++;
            checks++;
            if (instret_a !== 4'(exp_ret)) $display("FAIL instr_instret got %0d want %0d", instret_a, 4'(exp_ret));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        opc = 6'b000010;
        repeat (16) begin
            push(K_FETCH); push(K_DEC); push(K_JMP);
            while (sbq.size() > 0) begin
                ent_t e;
                e = sbq.pop_front();
                mem_ready = e.rdy; #1;
                checks++;
                if (oa !== e.exp) $display("FAIL wrap_j ctl=%h want %h", oa, e.exp);
                else passes++;
                @(negedge clk);
            end
            exp_ret++;
        end
        checks++;
        if (instret_a !== 4'(exp_ret) || exp_ret % 16 != 0)
            $display("FAIL wrap_instret got %0d want %0d", instret_a, 4'(exp_ret));
        else passes++;
    endtask

    task automatic test_trap();
        int held;
        held = exp_ret;
        opc = 6'b111111;
        push(K_FETCH); push(K_DEC);
        repeat (20) push(K_TI);
        apply_reset_pending: while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL trap_opc ctl=%h want %h", oa, e.exp);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (instret_a !== 4'(held)) $display("FAIL trap_instret got %0d want %0d", instret_a, 4'(held));
        else passes++;
        apply_reset();
        opc = 6'b000000; func = 6'b111111;
        push(K_FETCH); push(K_DEC); push(K_REX, 1'b1, 3'b000, 1'b0, 1'b0);
        repeat (3) push(K_TI);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            if (e.chk) begin
                checks++;
                if (oa !== e.exp) $display("FAIL trap_func ctl=%h want %h", oa, e.exp);
                else passes++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        opc = 6'b000010;
        push(K_FETCH); push(K_DEC); push(K_JMP);
        push(K_FETCH); push(K_DEC); push(K_MADDR); push(K_MWR, 1'b0); push(K_MWR, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            ent_t e;
            if (n == 3) opc = 6'b101011;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL mid_cyc%0d ctl=%h want %h", n, oa, e.exp);
            else passes++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (oa.MemWrite !== 1'b1 || instret_a !== 4'd1)
            $display("FAIL mid_pre MemWrite=%b instret=%0d want 1/1", oa.MemWrite, instret_a);
        else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (oa !== '0 || instret_a !== 4'd0)
            $display("FAIL mid_async ctl=%h instret=%0d want 0/0", oa, instret_a);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        push(K_ZERO); push(K_FETCH);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready = e.rdy; #1;
            checks++;
            if (oa !== e.exp) $display("FAIL mid_restart ctl=%h want %h", oa, e.exp);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        rst = 1'b0;
        rst_b = 1'b1;
        opc = 6'b100011;
        push(K_ZERO);
        push(K_FETCH, 1'b0); push(K_FETCH, 1'b0); push(K_FETCH, 1'b1);
        push(K_DEC); push(K_MADDR);
        push(K_MRD, 1'b0); push(K_MRD, 1'b0); push(K_MRD, 1'b1); push(K_MWB);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready_b = e.rdy; #1;
            checks++;
            if (ob !== e.exp) $display("FAIL tmo_edge ctl=%h want %h", ob, e.exp);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (instret_b !== 32'd1) $display("FAIL tmo_instret got %0d want 1", instret_b);
        else passes++;
        push(K_FETCH); push(K_DEC); push(K_MADDR);
        push(K_MRD, 1'b0); push(K_MRD, 1'b0); push(K_MRD, 1'b0);
        repeat (3) push(K_TM);
        while (sbq.size() > 0) begin
            ent_t e;
            e = sbq.pop_front();
            mem_ready_b = e.rdy; #1;
            checks++;
            if (ob !== e.exp) $display("FAIL tmo_trap ctl=%h want %h", ob, e.exp);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fetch_wait();
        test_branches();
        test_mem();
        test_jumps();
        test_wrap();
        test_trap();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mips_mc_ctrl_hs.md
# mips_mc_ctrl_hs

Multi-cycle MIPS control unit with a memory ready/wait handshake, a memory timeout, illegal-opcode trapping and a retired-instruction counter. It is the next generation of the multi-cycle core's controller and drives the same datapath control bus. It adds `jr`, `bne` and `slti`, and supports memories that take more than one cycle.

## Interface
- `MEM_WAIT_MAX`, 15: wait cycles allowed per memory access before timeout; must be ≥1.
- `PERF_W`, 32: width of `instret`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `opc` in 6: IR[31:26].
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `PCLoad` out 1: PC write enable.
- `IorD` out 1: 0 = PC address, 1 = ALUOut address.
- `IRWrite` out 1: IR write enable.
- `RegDst` out 1: 1 = rd, 0 = rt.
- `JalSig1` out 1: 1 = write register 31.
- `JalSig2` out 1: 1 = write data is PC.
- `MemToReg` out 1: 1 = MDR.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `RegWrite` out 1: register-file write enable.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2.
- `ALUOperation` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A.
- `illegal` out 1: sticky, set on an undefined opcode or func.
- `mem_err` out 1: sticky, set on memory timeout.
- `instret` out PERF_W: count of retired instructions.

## Operation
- **States:** RST, FETCH, DECODE, MADDR, MRD, MWB, MWR, REX, RWB, IEX, IWB, BR, JMP, JAL, JR, TRAP.
- **Encoding:** all outputs are Moore-decoded from state, except `IRWrite` and `PCLoad` in FETCH, which are gated by `mem_ready`.
- **RST → FETCH** unconditionally.
- **FETCH:** drives `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSrc`=00. When `mem_ready`=1, it asserts `IRWrite` and `PCLoad` and moves to DECODE; otherwise it stays.
- **DECODE:** drives `ALUSrcA`=0, `ALUSrcB`=11, add (precomputes the branch target). Dispatch by opcode:
  - 000000 → REX (func 001000 → JR).
  - 100011 / 101011 → MADDR.
  - 000100 / 000101 → BR.
  - 001000 / 001010 → IEX.
  - 000010 → JMP.
  - 000011 → JAL.
  - Anything else → TRAP with `illegal`=1.
- **REX:** `ALUSrcA`=1, `ALUSrcB`=00. Func maps to an ALU op: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other func → TRAP with `illegal`=1.
- **RWB:** `RegDst`=1, `RegWrite`=1 → FETCH.
- **IEX:** `ALUSrcB`=10; add for addi, slt for slti.
- **IWB:** `RegDst`=0, `RegWrite`=1 → FETCH.
- **MADDR:** `ALUSrcA`=1, `ALUSrcB`=10, add → MRD (lw) or MWR (sw).
- **MRD:** `MemRead`=1, `IorD`=1; waits for `mem_ready`, then → MWB.
- **MWB:** `MemToReg`=1, `RegWrite`=1, `RegDst`=0 → FETCH.
- **MWR:** `MemWrite`=1, `IorD`=1; waits for `mem_ready`, then → FETCH.
- **BR:** sub of A and B, `PCSrc`=01. `PCLoad` = `zero` for beq, `!zero` for bne → FETCH.
- **JMP:** `PCSrc`=10, `PCLoad` → FETCH.
- **JAL:** `JalSig1`=`JalSig2`=`RegWrite`=1, `PCSrc`=10, `PCLoad` in the same cycle; the register file captures the already-incremented PC.
- **JR:** `PCSrc`=11, `PCLoad` → FETCH.
- **Timeout:** the wait counter clears on entering FETCH, MRD or MWR and increments each waiting cycle with `mem_ready`=0. It reaches MEM_WAIT_MAX → TRAP with `mem_err`=1. A `mem_ready` arriving in that same cycle wins: no error.
- **TRAP:** all enables 0; it exits only by reset. No further PC, register or memory writes occur.
- **Retirement:** `instret` increments by 1 on each transition into FETCH from any state other than RST, and wraps modulo 2^PERF_W.

## Timing
- **Reset:** every output is 0 while `rst` is low and during the RST cycle, including `instret`, `illegal` and `mem_err`.
- **Zero-wait cycle counts:**
  - R-type: 4
  - addi / slti: 4
  - lw: 5
  - sw: 4
  - beq / bne: 3
  - j / jal / jr: 3
- **Wait states:** each memory wait cycle adds 1 cycle.
- **Reset mid-access:** the FSM returns to RST immediately and drops `MemRead`/`MemWrite` asynchronously.
- **`mem_ready` sampling:** sampled only in FETCH, MRD and MWR; ignored elsewhere.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and func constants;
  - ALU operation codes;
  - `ALUSrcB` and `PCSrc` encodings;
  - the state enum.
- Sub-module `mem_wait_timer`: parametrised by MEM_WAIT_MAX. Inputs are `clr` and `wait_en`; the output is `expired`. It uses the same asynchronous active-low reset.

## Test plan
- **Fetch with waits:** R-type add, `mem_ready` high 2 cycles after FETCH entry → `IRWrite`/`PCLoad` pulse once in the 3rd FETCH cycle, then DECODE→REX→RWB with `RegDst`=1 and `RegWrite`=1; `instret` becomes 1.
- **bne:** bne with `zero`=0 → `PCLoad`=1 and `PCSrc`=01 in BR. bne with `zero`=1 → `PCLoad`=0.
- **lw:** lw, zero-wait → 5 cycles, MWB asserts `MemToReg`=1 and `RegWrite`=1. sw with 3 wait cycles → `MemWrite` held for 4 cycles.
- **jal / jr:** jal → single JAL cycle with `JalSig1`, `JalSig2`, `RegWrite`, `PCLoad` all 1 and `PCSrc`=10. jr (func 001000) → `PCSrc`=11.
- **Traps:** opcode 111111 → TRAP, `illegal`=1, all enables stay 0 for 20 cycles. With MEM_WAIT_MAX=3, `mem_ready` held low in MRD → `mem_err`=1 after 3 wait cycles.
- **Reset and wrap:** `rst` low mid-MWR → all outputs 0 asynchronously; after release, RST then FETCH. With PERF_W=4, 16 retirements → `instret` wraps to 0.
